// File: rtl/ln_pkg.sv
// ln_pkg: shared types, width helpers, saturation and rounding for the moment unit
package ln_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, MUL, OUT} state_t;

    localparam int WIDE_W = 64;

    function automatic int xs_width(input int data_w, input int alpha_w);
        return data_w + (1 << alpha_w) - 1;
    endfunction

    function automatic int acc_width(input int term_w, input int len_w, input int lanes);
        return term_w + $clog2(((1 << len_w) - 1) * lanes);
    endfunction

    function automatic logic signed [WIDE_W-1:0] sat_s(input logic signed [WIDE_W-1:0] v, input int w);
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction

    function automatic logic [WIDE_W-1:0] sat_u(input logic [WIDE_W-1:0] v, input int w);
        logic [WIDE_W-1:0] hi;
        hi = (64'd1 << w) - 64'd1;
        return (v > hi) ? hi : v;
    endfunction

    function automatic logic signed [WIDE_W-1:0] rnd_half(input int frac_w);
        return 64'sd1 <<< (frac_w - 1);
    endfunction

endpackage

// File: rtl/ln_moment_lane.sv
// ln_moment_lane: scales one sample by 2^alpha and squares it
module ln_moment_lane import ln_pkg::*; #(
    parameter int DATA_W = 9,
    parameter int ALPHA_W = 2,
    localparam int XS_W = xs_width(DATA_W, ALPHA_W)
) (
    input  logic signed [DATA_W-1:0]  i_x,
    input  logic        [ALPHA_W-1:0] i_alpha,
    output logic signed [XS_W-1:0]    o_xs,
    output logic        [2*XS_W-1:0]  o_sq
);

    logic signed [XS_W-1:0]   xe;
    logic signed [2*XS_W-1:0] xw;

    assign xe   = XS_W'(i_x);
    assign o_xs = xe <<< i_alpha;
    assign xw   = (2*XS_W)'(o_xs);
    assign o_sq = $unsigned(xw * xw);

endmodule

// File: rtl/ln_moment_unit.sv
// ln_moment_unit: multi-lane E[x] / E[x^2] accumulator with fixed-point 1/N scaling
module ln_moment_unit import ln_pkg::*; #(
    parameter int DATA_W   = 9,
    parameter int LANES    = 2,
    parameter int LEN_W    = 8,
    parameter int ALPHA_W  = 2,
    parameter int INV_W    = 8,
    parameter int OUT_W    = 8,
    parameter int SQ_OUT_W = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [LEN_W-1:0]          i_len,
    input  logic [ALPHA_W-1:0]        i_alpha,
    input  logic [INV_W-1:0]          i_inv_n,
    input  logic                      i_valid,
    input  logic [LANES*DATA_W-1:0]   i_x,
    output logic                      o_ready,
    output logic                      o_busy,
    output logic                      o_done,
    output logic signed [OUT_W-1:0]   o_ex,
    output logic [SQ_OUT_W-1:0]       o_ex2,
    output logic                      o_sat
);

    localparam int XS_W   = xs_width(DATA_W, ALPHA_W);
    localparam int SQ_W   = 2 * XS_W;
    localparam int ACC1_W = acc_width(XS_W, LEN_W, LANES);
    localparam int ACC2_W = acc_width(SQ_W, LEN_W, LANES);

    state_t                    state_q;
    logic [LEN_W-1:0]          len_q;
    logic [LEN_W-1:0]          cnt_q;
    logic [ALPHA_W-1:0]        alpha_q;
    logic [INV_W-1:0]          inv_q;
    logic signed [ACC1_W-1:0]  sum1_q, sum1_d;
    logic [ACC2_W-1:0]         sum2_q, sum2_d;
    logic signed [OUT_W-1:0]   ex_q, ex_d;
    logic [SQ_OUT_W-1:0]       ex2_q, ex2_d;
    logic                      sat_q, sat_d;
    logic                      done_q;

    logic signed [XS_W-1:0]    lane_xs [LANES];
    logic [SQ_W-1:0]           lane_sq [LANES];

    logic signed [WIDE_W-1:0]  p1, r1, e1;
    logic [WIDE_W-1:0]         p2, r2, e2;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        ln_moment_lane #(.DATA_W(DATA_W), .ALPHA_W(ALPHA_W)) u_lane (
            .i_x     (i_x[g*DATA_W +: DATA_W]),
            .i_alpha (alpha_q),
            .o_xs    (lane_xs[g]),
            .o_sq    (lane_sq[g])
        );
    end

    // Running sums plus this beat's lane contributions; widths are sized so they never wrap
    always_comb begin
        sum1_d = sum1_q;
        sum2_d = sum2_q;
        for (int l = 0; l < LANES; l++) begin
            sum1_d = sum1_d + ACC1_W'(lane_xs[l]);
            sum2_d = sum2_d + ACC2_W'(lane_sq[l]);
        end
    end

    // Full-width products with 1/N, round half up, then clamp to the output ranges
    assign p1    = WIDE_W'(sum1_q) * $signed({{(WIDE_W-INV_W){1'b0}}, inv_q});
    assign r1    = (p1 + rnd_half(INV_W)) >>> INV_W;
    assign e1    = sat_s(r1, OUT_W);
    assign p2    = WIDE_W'(sum2_q) * {{(WIDE_W-INV_W){1'b0}}, inv_q};
    assign r2    = (p2 + $unsigned(rnd_half(INV_W))) >> INV_W;
    assign e2    = sat_u(r2, SQ_OUT_W);
    assign ex_d  = e1[OUT_W-1:0];
    assign ex2_d = e2[SQ_OUT_W-1:0];
    assign sat_d = (e1 != r1) || (e2 != r2);

    // Control FSM: results latch on the MUL cycle so the done pulse lines up with OUT
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            alpha_q <= '0;
            inv_q   <= '0;
            sum1_q  <= '0;
            sum2_q  <= '0;
            ex_q    <= '0;
            ex2_q   <= '0;
            sat_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (i_start) begin
                    len_q   <= i_len;
                    alpha_q <= i_alpha;
                    inv_q   <= i_inv_n;
                    cnt_q   <= '0;
                    sum1_q  <= '0;
                    sum2_q  <= '0;
                    state_q <= (i_len == '0) ? MUL : ACCUM;
                end
                ACCUM: if (i_valid) begin
                    sum1_q <= sum1_d;
                    sum2_q <= sum2_d;
                    cnt_q  <= cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1)) state_q <= MUL;
                end
                MUL: begin
                    ex_q    <= ex_d;
                    ex2_q   <= ex2_d;
                    sat_q   <= sat_d;
                    done_q  <= 1'b1;
                    state_q <= OUT;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ready = (state_q == ACCUM);
    assign o_busy  = (state_q != IDLE);
    assign o_done  = done_q;
    assign o_ex    = ex_q;
    assign o_ex2   = ex2_q;
    assign o_sat   = sat_q;

endmodule

// File: tb/tb_ln_moment_unit.sv
// tb_ln_moment_unit: directed and random checks of the moment unit against an arithmetic model
module tb_ln_moment_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] alpha = '0;
    logic [7:0] inv = '0;

    logic start1 = 1'b0, valid1 = 1'b0;
    logic [7:0] len1 = '0;
    logic [8:0] x1 = '0;
    logic rdy1, busy1, done1, sat1;
    logic signed [7:0] ex_a;
    logic [15:0] ex2_a;

    logic start2 = 1'b0, valid2 = 1'b0;
    logic [7:0] len2 = '0;
    logic [17:0] x2 = '0;
    logic rdy2, busy2, done2, sat2;
    logic signed [7:0] ex_b;
    logic [15:0] ex2_b;

    int nvec = 0;
    int nerr = 0;
    int q[$];
    longint m_ex, m_ex2, m_sat;

    ln_moment_unit #(.LANES(1)) u1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .i_len(len1), .i_alpha(alpha),
        .i_inv_n(inv), .i_valid(valid1), .i_x(x1), .o_ready(rdy1), .o_busy(busy1),
        .o_done(done1), .o_ex(ex_a), .o_ex2(ex2_a), .o_sat(sat1)
    );

    ln_moment_unit #(.LANES(2)) u2 (
        .i_clk(clk), .i_rst(rst), .i_start(start2), .i_len(len2), .i_alpha(alpha),
        .i_inv_n(inv), .i_valid(valid2), .i_x(x2), .o_ready(rdy2), .o_busy(busy2),
        .o_done(done2), .o_ex(ex_b), .o_ex2(ex2_b), .o_sat(sat2)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic void model(input int a, input int inv_n);
        longint s1, s2, r1, r2;
        s1 = 0;
        s2 = 0;
        foreach (q[i]) begin
            longint v;
            v = longint'(q[i]) * (longint'(1) << a);
            s1 += v;
            s2 += v * v;
        end
        r1 = (s1 * inv_n + 128) >>> 8;
        r2 = (s2 * inv_n + 128) >>> 8;
        m_ex  = (r1 > 127) ? 127 : (r1 < -128) ? -128 : r1;
        m_ex2 = (r2 > 65535) ? 65535 : r2;
        m_sat = (m_ex != r1 || m_ex2 != r2) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run1(input int a, input int inv_n, input bit gap, input bit disturb);
        int i, cyc;
        bit acc;
        model(a, inv_n);
        alpha = 2'(a);
        inv = 8'(inv_n);
        len1 = 8'(q.size());
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        i = 0;
        cyc = 0;
        while (i < q.size() && cyc < 200) begin
            valid1 = !(gap && (cyc % 2 == 1));
            x1 = q[i][8:0];
            start1 = disturb && (i == q.size() / 2);
            if (start1) begin
                alpha = alpha + 2'd1;
                inv = ~inv;
                len1 = 8'd2;
            end
            acc = valid1 && rdy1;
            step();
            cyc++;
            if (acc) i++;
        end
        valid1 = 1'b0;
        start1 = 1'b0;
        chk("l1_beats", i, q.size());
        chk("l1_done_k1", done1, 0);
        step();
        chk("l1_done_k2", done1, 1);
        chk("l1_ex", ex_a, m_ex);
        chk("l1_ex2", ex2_a, m_ex2);
        chk("l1_sat", sat1, m_sat);
        step();
        chk("l1_done_clr", done1, 0);
        chk("l1_busy_end", busy1, 0);
    endtask

    task automatic run2(input int a, input int inv_n);
        int i, cyc;
        bit acc;
        model(a, inv_n);
        alpha = 2'(a);
        inv = 8'(inv_n);
        len2 = 8'(q.size() / 2);
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        i = 0;
        cyc = 0;
        while (2 * i < q.size() && cyc < 200) begin
            valid2 = 1'b1;
            x2 = {q[2*i+1][8:0], q[2*i][8:0]};
            acc = rdy2;
            step();
            cyc++;
            if (acc) i++;
        end
        valid2 = 1'b0;
        chk("l2_beats", 2 * i, q.size());
        chk("l2_done_k1", done2, 0);
        step();
        chk("l2_done_k2", done2, 1);
        chk("l2_ex", ex_b, m_ex);
        chk("l2_ex2", ex2_b, m_ex2);
        chk("l2_sat", sat2, m_sat);
        step();
        chk("l2_busy_end", busy2, 0);
    endtask

    task automatic rand_q(input int n);
        q.delete();
        for (int k = 0; k < n; k++) q.push_back(int'($urandom_range(511)) - 256);
    endtask

    initial begin
        #2;
        chk("rst_ready", rdy1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_ex", ex_a, 0);
        chk("rst_ex2", ex2_a, 0);
        chk("rst_sat", sat1, 0);
        step();
        rst = 1'b0;
        step();

        q = '{1, 2, 3, 4, 5, 6, 7, 8};
        run1(2, 32, 1'b0, 1'b0);
        chk("tp1_ex_const", ex_a, 18);
        chk("tp1_ex2_const", ex2_a, 408);

        run2(2, 32);
        chk("tp2_ex_const", ex_b, 18);
        chk("tp2_ex2_const", ex2_b, 408);

        run1(2, 32, 1'b1, 1'b1);
        chk("tp3_ex_const", ex_a, 18);
        chk("tp3_ex2_const", ex2_a, 408);

        len1 = 8'd0;
        x1 = 9'd5;
        valid1 = 1'b1;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        chk("len0_ready", rdy1, 0);
        chk("len0_busy", busy1, 1);
        chk("len0_done_s1", done1, 0);
        step();
        chk("len0_done_s2", done1, 1);
        chk("len0_ex", ex_a, 0);
        chk("len0_ex2", ex2_a, 0);
        chk("len0_sat", sat1, 0);
        step();
        valid1 = 1'b0;
        chk("len0_busy_end", busy1, 0);

        q = '{255};
        run1(3, 255, 1'b0, 1'b0);
        chk("satp_ex", ex_a, 127);
        chk("satp_flag", sat1, 1);
        q = '{-256};
        run1(3, 255, 1'b0, 1'b0);
        chk("satn_ex", ex_a, -128);
        chk("satn_flag", sat1, 1);

        len1 = 8'd8;
        alpha = 2'd2;
        inv = 8'd32;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        valid1 = 1'b1;
        x1 = 9'd100;
        step();
        step();
        step();
        chk("pre_rst_ready", rdy1, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ready", rdy1, 0);
        chk("arst_busy", busy1, 0);
        chk("arst_done", done1, 0);
        chk("arst_ex", ex_a, 0);
        chk("arst_ex2", ex2_a, 0);
        chk("arst_sat", sat1, 0);
        valid1 = 1'b0;
        step();
        rst = 1'b0;
        step();
        rand_q(8);
        run1(1, 32, 1'b0, 1'b0);

        for (int t = 0; t < 8; t++) begin
            int a, iv;
            a = int'($urandom_range(3));
            iv = int'($urandom_range(255));
            if (t % 2 == 0) begin
                rand_q(int'($urandom_range(12, 1)));
                run1(a, iv, t % 4 == 2, 1'b0);
            end else begin
                rand_q(2 * int'($urandom_range(12, 1)));
                run2(a, iv);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
